// File: rtl/kbd_cursor_ctrl.sv
// Keyboard direction code to clamped cursor position, with single-step on a new
// key, hold delay and auto-repeat. All outputs registered for the overlay stage.
module kbd_cursor_ctrl #(
  parameter int H_MAX         = 640,
  parameter int V_MAX         = 480,
  parameter int CUR_W         = 8,
  parameter int CUR_H         = 8,
  parameter int STEP          = 8,
  parameter int HOLD_DELAY    = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] ps2OutCode,
  output logic [9:0] cursorX,
  output logic [9:0] cursorY,
  output logic       moved,
  output logic [3:0] atEdge
);

  localparam logic [9:0]  X_MAX      = 10'(H_MAX - CUR_W);
  localparam logic [9:0]  Y_MAX      = 10'(V_MAX - CUR_H);
  localparam logic [9:0]  X_HOME     = 10'((H_MAX - CUR_W) / 2);
  localparam logic [9:0]  Y_HOME     = 10'((V_MAX - CUR_H) / 2);
  localparam logic [9:0]  STEP10     = 10'(STEP);
  localparam logic [10:0] STEP11     = 11'(STEP);
  localparam logic [23:0] HOLD_LOAD  = 24'(HOLD_DELAY - 1);
  localparam logic [23:0] REPT_LOAD  = 24'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  // Encodings match the keyboard codes so a valid code casts directly to an action.
  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_UP    = 3'd1,
    ACT_DOWN  = 3'd2,
    ACT_LEFT  = 3'd3,
    ACT_RIGHT = 3'd4,
    ACT_HOME  = 3'd5
  } act_t;

  state_t      state, state_nxt;
  logic [23:0] timer, timer_nxt;
  logic [2:0]  code_in, code_q, prev_q;
  act_t        act;
  logic [9:0]  x_nxt, y_nxt;
  logic [10:0] x_sum, y_sum;

  assign code_in = (ps2OutCode >= 4'd1 && ps2OutCode <= 4'd5) ? ps2OutCode[2:0] : 3'd0;

  // NOTE: every register, including the code pipeline, is cleared by reset so a
  // key held across reset release is seen as a fresh press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      code_q <= '0;
      prev_q <= '0;
      state  <= S_IDLE;
      timer  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep prev_q sampling the old code_q.
      code_q <= code_in;
      prev_q <= code_q;
      state  <= state_nxt;
      timer  <= timer_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nxt = state;
    timer_nxt = timer;
    act       = ACT_NONE;
    if (code_q == 3'd0) begin
      state_nxt = S_IDLE;
    end else if (code_q != prev_q) begin
      act = act_t'(code_q);
      if (code_q == 3'd5) begin
        state_nxt = S_IDLE;
      end else begin
        state_nxt = S_HOLD;
        timer_nxt = HOLD_LOAD;
      end
    end else begin
      case (state)
        S_HOLD, S_REPEAT: begin
          if (timer == '0) begin
            act       = act_t'(code_q);
            state_nxt = S_REPEAT;
            timer_nxt = REPT_LOAD;
          end else begin
            timer_nxt = timer - 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Widened sums so a step past the far edge clamps instead of wrapping.
  assign x_sum = {1'b0, cursorX} + STEP11;
  assign y_sum = {1'b0, cursorY} + STEP11;

  always_comb begin
    x_nxt = cursorX;
    y_nxt = cursorY;
    case (act)
      ACT_UP:    y_nxt = (cursorY < STEP10) ? 10'd0 : cursorY - STEP10;
      ACT_DOWN:  y_nxt = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[9:0];
      ACT_LEFT:  x_nxt = (cursorX < STEP10) ? 10'd0 : cursorX - STEP10;
      ACT_RIGHT: x_nxt = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
      ACT_HOME: begin
        x_nxt = X_HOME;
        y_nxt = Y_HOME;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cursorX <= X_HOME;
      cursorY <= Y_HOME;
      moved   <= 1'b0;
      atEdge  <= '0;
    end else begin
      cursorX <= x_nxt;
      cursorY <= y_nxt;
      moved   <= (x_nxt != cursorX) || (y_nxt != cursorY);
      atEdge  <= {y_nxt == 10'd0, y_nxt == Y_MAX, x_nxt == 10'd0, x_nxt == X_MAX};
    end
  end

endmodule

// File: tb/tb_kbd_cursor_ctrl.sv
// Scoreboard bench for kbd_cursor_ctrl: stimulus queues expected moves (cycle,
// position, edge flags); a negedge monitor pops and compares on every moved pulse.
module tb_kbd_cursor_ctrl;

  localparam int HD = 20;
  localparam int RP = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] code = 4'd0;
  logic [9:0] cursor_x, cursor_y;
  logic       moved;
  logic [3:0] at_edge;

  kbd_cursor_ctrl #(.HOLD_DELAY(HD), .REPEAT_PERIOD(RP)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2OutCode (code),
    .cursorX    (cursor_x),
    .cursorY    (cursor_y),
    .moved      (moved),
    .atEdge     (at_edge)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] edg;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_move(input int c, input int x, input int y, input int e);
    sb.push_back('{c, 10'(x), 10'(y), 4'(e)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Step n of a held key lands at c+2, then c+2+HD, then every RP cycles.
  function automatic int step_cycle(input int c, input int n);
    return (n == 1) ? c + 2 : c + 2 + HD + RP * (n - 2);
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && moved === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_move", int'(moved), 0);
      end else begin
        e = sb.pop_front();
        check("move_cycle", cyc, e.cyc);
        check("move_x", cursor_x, e.x);
        check("move_y", cursor_y, e.y);
        check("move_edge", at_edge, e.edg);
      end
    end
  end

  initial begin
    int c;
    int r;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_x", cursor_x, 316);
    check("rst_y", cursor_y, 236);
    check("rst_moved", moved, 0);
    check("rst_edge", at_edge, 0);
    tick(2);
    reset = 1'b1;
    tick(3);

    // Single press of right.
    c = cyc; code = 4'd4;
    expect_move(c + 2, 324, 236, 0);
    tick(3); code = 4'd0;
    tick(30);
    drain("single_pending");
    check("single_x", cursor_x, 324);

    // Held up: immediate step, hold delay, then repeats; nothing after release.
    c = cyc; code = 4'd1;
    expect_move(c + 2,  324, 228, 0);
    expect_move(c + 22, 324, 220, 0);
    expect_move(c + 27, 324, 212, 0);
    expect_move(c + 32, 324, 204, 0);
    expect_move(c + 37, 324, 196, 0);
    tick(40); code = 4'd0;
    tick(30);
    drain("repeat_pending");
    check("repeat_y", cursor_y, 196);

    // Down then switch to left mid-hold: left restarts the full hold delay.
    c = cyc; code = 4'd2;
    expect_move(c + 2, 324, 204, 0);
    tick(10); code = 4'd3;
    expect_move(c + 12, 316, 204, 0);
    expect_move(c + 32, 308, 204, 0);
    tick(25); code = 4'd0;
    tick(30);
    drain("change_pending");

    // Held left down to X=4, released just before the clamping step.
    c = cyc; code = 4'd3;
    for (int n = 1; n <= 38; n++) expect_move(step_cycle(c, n), 308 - 8 * n, 204, 0);
    tick(203); code = 4'd0;
    tick(30);
    drain("left_run_pending");
    check("left_run_x", cursor_x, 4);

    // Left from X=4 clamps to 0; a further left is a silent no-op.
    c = cyc; code = 4'd3;
    expect_move(c + 2, 0, 204, 4'b0010);
    tick(3); code = 4'd0;
    tick(10);
    drain("clamp_left_pending");
    code = 4'd3;
    tick(3); code = 4'd0;
    tick(10);
    check("clamp_left_x", cursor_x, 0);
    check("clamp_left_edge", at_edge, 4'b0010);

    // Held up to Y=0, then several clamped repeats that must not pulse moved.
    c = cyc; code = 4'd1;
    for (int n = 1; n <= 26; n++)
      expect_move(step_cycle(c, n), 0, (n < 26) ? 204 - 8 * n : 0, (n < 26) ? 4'b0010 : 4'b1010);
    tick(160); code = 4'd0;
    tick(20);
    drain("up_run_pending");
    check("corner_y", cursor_y, 0);
    check("corner_edge", at_edge, 4'b1010);

    // Home from the corner, held without repeat; code 9 is ignored.
    c = cyc; code = 4'd5;
    expect_move(c + 2, 316, 236, 0);
    tick(30); code = 4'd9;
    tick(10); code = 4'd0;
    tick(10);
    drain("home_pending");
    check("home_x", cursor_x, 316);
    check("home_y", cursor_y, 236);

    // Held right to the clamp at 632, released with an invalid code.
    c = cyc; code = 4'd4;
    for (int n = 1; n <= 40; n++)
      expect_move(step_cycle(c, n), (n < 40) ? 316 + 8 * n : 632, 236, (n < 40) ? 0 : 4'b0001);
    tick(230); code = 4'd9;
    tick(20); code = 4'd0;
    drain("right_run_pending");
    check("clamp_right_x", cursor_x, 632);
    check("clamp_right_edge", at_edge, 4'b0001);

    // Reset mid-repeat with left still held; held key restarts after release.
    c = cyc; code = 4'd3;
    expect_move(c + 2,  624, 236, 0);
    expect_move(c + 22, 616, 236, 0);
    expect_move(c + 27, 608, 236, 0);
    tick(29);
    #2 reset = 1'b0;
    #1;
    check("async_rst_x", cursor_x, 316);
    check("async_rst_y", cursor_y, 236);
    check("async_rst_moved", moved, 0);
    check("async_rst_edge", at_edge, 0);
    drain("pre_reset_pending");
    tick(2);
    r = cyc; reset = 1'b1;
    expect_move(r + 2, 308, 236, 0);
    tick(5); code = 4'd0;
    tick(10);
    drain("post_reset_pending");
    check("post_reset_x", cursor_x, 308);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_cursor_ctrl.md
# kbd_cursor_ctrl

Converts the 4-bit direction code produced by the keyboard controller into an on-screen cursor position for the VGA pixel pipeline. It sits directly downstream of the keyboard controller's code output. It steps the cursor once on each new key code, auto-repeats while a code is held, and clamps the cursor to the visible area. Registered X/Y coordinates, a move strobe and edge flags go to the sprite/overlay stage.

## Interface
- H_MAX, 640: visible width in pixels.
- V_MAX, 480: visible height in pixels.
- CUR_W, 8: cursor width; max X = H_MAX-CUR_W.
- CUR_H, 8: cursor height; max Y = V_MAX-CUR_H.
- STEP, 8: pixels per move.
- HOLD_DELAY, 12_500_000: cycles from first step to first repeat.
- REPEAT_PERIOD, 2_500_000: cycles between repeats.
- clock  in  1  system clock, same domain as the keyboard controller.
- reset  in  1  asynchronous, active-low reset.
- ps2OutCode  in  4  level code from the keyboard controller. 1=up, 2=down, 3=left, 4=right, 5=home, 0 and 6..15=no key.
- cursorX  out  10  cursor left-edge X, registered.
- cursorY  out  10  cursor top-edge Y, registered.
- moved  out  1  one-cycle pulse in the cycle where cursorX/cursorY take a new value.
- atEdge  out  4  registered flags {top, bottom, left, right}. A flag is set when the cursor sits at that bound.

## Operation
- Input register: codeQ <= ps2OutCode every clock. Codes 0 and 6..15 are mapped to 0 (idle). All decisions use codeQ and prevQ, where prevQ is codeQ delayed by one cycle.
- State machine, states IDLE / HOLD / REPEAT. Timer: 24-bit down-counter.
  - Any state, codeQ != prevQ and codeQ != 0: apply one action for codeQ. For codes 1..4, load the timer with HOLD_DELAY-1 and go to HOLD. For code 5, go to IDLE; home never repeats.
  - Any state, codeQ == 0: go to IDLE, no action. A release overrides a pending repeat.
  - HOLD, code unchanged: decrement the timer. At 0, apply one action, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT, code unchanged: decrement the timer. At 0, apply one action and reload REPEAT_PERIOD-1.
  - IDLE, code unchanged: no action.
- Actions, all clamped. Arithmetic is 11 bits wide, so no wrap-around at 0 or at max.
  - up: Y = (Y < STEP) ? 0 : Y-STEP.
  - down: Y = (Y+STEP > V_MAX-CUR_H) ? V_MAX-CUR_H : Y+STEP.
  - left: X = (X < STEP) ? 0 : X-STEP.
  - right: X = (X+STEP > H_MAX-CUR_W) ? H_MAX-CUR_W : X+STEP.
  - home: X = (H_MAX-CUR_W)/2, Y = (V_MAX-CUR_H)/2.
- moved is asserted only if the position actually changes. A clamped no-op action keeps moved at 0 but still advances the repeat timer.
- atEdge is recomputed from the new position in the same register update.

## Timing
- Reset (reset=0, asynchronous):
  - cursorX=316, cursorY=236 (home with the default parameters).
  - moved=0, atEdge=0, codeQ=prevQ=0, state IDLE, timer 0.
  - Release of reset is synchronous to clock, and no action occurs in the first cycle after release.
- Latency: ps2OutCode changes before edge k. codeQ updates at edge k. cursorX/cursorY, atEdge and moved update at edge k+1.
- A code held from edge k gives:
  - first step at edge k+1;
  - second step at edge k+1+HOLD_DELAY;
  - further steps every REPEAT_PERIOD cycles after that.
- A direct change from one direction code to another (for example 4 to 1) restarts the sequence: immediate step, full HOLD_DELAY.
- Reset asserted mid-repeat drops all state immediately. A code still held at reset release counts as a new press (prevQ=0) at the first edge after release.

## Test plan
- Reset: assert reset=0 mid-run -> cursorX=316, cursorY=236, moved=0, atEdge=0 asynchronously, before the next clock edge.
- Single press (HOLD_DELAY=20, REPEAT_PERIOD=5): ps2OutCode 0->4 for 3 cycles, then 0 -> cursorX=324 exactly 2 edges after the change, moved pulses once, no further moves.
- Auto-repeat (same params): hold code 1 for 40 cycles -> Y steps to 228 at edge k+1, 220 at k+21, then 212/204/196 at k+26/k+31/k+36, and nothing after release.
- Clamp: start at X=4, press left -> X=0, atEdge[1]=1, moved=1. Press left again -> X stays 0, moved=0. Repeat right from 628 -> X=632, atEdge[0]=1, then no-ops.
- Code change mid-hold: hold 2, switch to 3 at cycle 10 -> immediate left step, next left step exactly HOLD_DELAY later, no further down steps.
- Home and invalid codes: move to (0,0), send 5 -> (316,236) after 2 edges, no repeat while held. Send 9 -> ignored, treated as a release.
